display_unit: RTL and testbench

DISPLAY_UNIT -- requirements
Module: display_unit

---
 rtl/display_pkg.sv | 46 ++++
 rtl/seg7_decoder.sv | 25 ++
 rtl/display_unit.sv | 86 ++++++++
 tb/tb_display_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 3-digit seven-segment display:
// segment patterns (a..g,dp in bits 7..0), active-low digit-select codes.
package display_pkg;

    localparam logic [7:0] SEG_0     = 8'b1111_1100;
    localparam logic [7:0] SEG_1     = 8'b0110_0000;
    localparam logic [7:0] SEG_2     = 8'b1101_1010;
    localparam logic [7:0] SEG_3     = 8'b1111_0010;
    localparam logic [7:0] SEG_4     = 8'b0110_0110;
    localparam logic [7:0] SEG_5     = 8'b1011_0110;
    localparam logic [7:0] SEG_6     = 8'b1011_1110;
    localparam logic [7:0] SEG_7     = 8'b1110_0000;
    localparam logic [7:0] SEG_8     = 8'b1111_1110;
    localparam logic [7:0] SEG_9     = 8'b1111_0110;
    localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

    localparam logic [7:0] COM_ONES  = 8'b1111_1110;
    localparam logic [7:0] COM_TENS  = 8'b1111_1101;
    localparam logic [7:0] COM_HUNDS = 8'b1111_1011;
    localparam logic [7:0] COM_OFF   = 8'b1111_1111;

    typedef enum logic [1:0] {
        DIG_ONES  = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_HUNDS = 2'd2
    } digit_sel_e;

    function automatic logic [7:0] com_code(input digit_sel_e sel);
        case (sel)
            DIG_ONES:  com_code = COM_ONES;
            DIG_TENS:  com_code = COM_TENS;
            DIG_HUNDS: com_code = COM_HUNDS;
            default:   com_code = COM_OFF;
        endcase
    endfunction

    // Scan order ones -> tens -> hundreds -> ones; the unused code 3 falls back to ones.
    function automatic digit_sel_e next_digit(input digit_sel_e sel);
        case (sel)
            DIG_ONES:  next_digit = DIG_TENS;
            DIG_TENS:  next_digit = DIG_HUNDS;
            default:   next_digit = DIG_ONES;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to seven-segment pattern; non-decimal codes blank the digit.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] pattern
);

    always_comb begin
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_unit.sv
// Time-multiplexed 3-digit decimal display driver for an 8-bit binary value,
// each digit held for DIGIT_CYCLES clocks, outputs registered.
module display_unit
    import display_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] value,
    output logic [7:0] seg_COM,
    output logic [7:0] seg_DATA
);

    localparam int unsigned CW = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    digit_sel_e    idx_q, idx_d;
    logic [7:0]    com_q, com_d;
    logic [7:0]    data_q, data_d;

    logic [3:0]    ones, tens, hunds;
    logic [3:0]    cur_digit;
    logic [7:0]    cur_pattern;

    always_comb begin
        hunds = 4'(value / 8'd100);
        tens  = 4'((value / 8'd10) % 8'd10);
        ones  = 4'(value % 8'd10);
    end

    always_comb begin
        case (idx_q)
            DIG_TENS:  cur_digit = tens;
            DIG_HUNDS: cur_digit = hunds;
            default:   cur_digit = ones;
        endcase
    end

    seg7_decoder u_dec (
        .digit   (cur_digit),
        .pattern (cur_pattern)
    );

    // Outputs are computed from the pre-edge index so COM and DATA always
    // describe the same digit, and a value change lands on the next edge.
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        com_d  = COM_OFF;
        data_d = SEG_BLANK;
        if (enable) begin
            com_d  = com_code(idx_q);
            data_d = cur_pattern;
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = next_digit(idx_q);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
            idx_d = DIG_ONES;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= DIG_ONES;
            com_q  <= COM_OFF;
            data_q <= SEG_BLANK;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            com_q  <= com_d;
            data_q <= data_d;
        end
    end

    assign seg_COM  = com_q;
    assign seg_DATA = data_q;

endmodule

// File: tb/tb_display_unit.sv
// Randomized and directed bench for display_unit against a cycle-level
// reference model derived from scan timing arithmetic.
module tb_display_unit;

    localparam int unsigned DC = 256;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] value;
    logic [7:0] seg_COM;
    logic [7:0] seg_DATA;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [7:0] lut [10];
    int unsigned t_model = 0;

    display_unit #(.DIGIT_CYCLES(DC)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .value    (value),
        .seg_COM  (seg_COM),
        .seg_DATA (seg_DATA)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int digit_of(input int v, input int pos);
        if (pos == 0) return v % 10;
        if (pos == 1) return (v / 10) % 10;
        return v / 100;
    endfunction

    function automatic int pos_of_com(input logic [7:0] c);
        for (int i = 0; i < 3; i++)
            if (c == ~(8'd1 << i)) return i;
        return -1;
    endfunction

    // Reference: while scanning, the digit shown after an edge is
    // floor(cycles since scan start / DC) mod 3, using the value present at that edge.
    always @(posedge clk) begin : model
        logic [7:0] ec, ed;
        int pos;
        if (rst || !enable) begin
            ec = 8'hFF;
            ed = 8'h00;
            t_model = 0;
        end else begin
            pos = int'((t_model / DC) % 3);
            ec  = ~(8'd1 << pos);
            ed  = lut[digit_of(int'(value), pos)];
            t_model++;
        end
        #1;
        check("mon_com", {24'd0, seg_COM}, {24'd0, ec});
        check("mon_data", {24'd0, seg_DATA}, {24'd0, ed});
        check("mon_onehot", ($countones(~seg_COM) <= 1) ? 32'd1 : 32'd0, 32'd1);
    end

    task automatic sample;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int cnt [3];
        int pos;
        int seen [3];
        int vals [4];
        int vseq [3];
        bit found;

        lut[0] = 8'b1111_1100; lut[1] = 8'b0110_0000; lut[2] = 8'b1101_1010;
        lut[3] = 8'b1111_0010; lut[4] = 8'b0110_0110; lut[5] = 8'b1011_0110;
        lut[6] = 8'b1011_1110; lut[7] = 8'b1110_0000; lut[8] = 8'b1111_1110;
        lut[9] = 8'b1111_0110;

        rst = 1'b1; enable = 1'b0; value = 8'd123;
        repeat (3) sample();
        check("rst_com", {24'd0, seg_COM}, 32'hFF);
        check("rst_data", {24'd0, seg_DATA}, 32'h00);

        // Disabled for 1000 ns: blank throughout.
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            sample();
            check("dis_com", {24'd0, seg_COM}, 32'hFF);
            check("dis_data", {24'd0, seg_DATA}, 32'h00);
        end

        // 123: digits 3/2/1 each for exactly DC cycles, ones first.
        @(negedge clk) enable = 1'b1;
        cnt = '{0, 0, 0};
        for (int k = 0; k < 3 * int'(DC); k++) begin
            sample();
            if (k == 0) check("en_first_ones", {24'd0, seg_COM}, 32'hFE);
            pos = pos_of_com(seg_COM);
            check("scan_com_valid", (pos >= 0) ? 32'd1 : 32'd0, 32'd1);
            if (pos >= 0) begin
                cnt[pos]++;
                check("scan_data", {24'd0, seg_DATA}, {24'd0, lut[digit_of(123, pos)]});
            end
        end
        for (int p = 0; p < 3; p++) check("dwell_len", cnt[p], DC);

        // Captured digits for several held values.
        vals = '{0, 42, 9, 255};
        for (int v = 0; v < 4; v++) begin
            @(negedge clk) value = 8'(vals[v]);
            seen = '{-1, -1, -1};
            for (int k = 0; k < 2000; k++) begin
                sample();
                pos = pos_of_com(seg_COM);
                if (pos >= 0 && k > 0) begin
                    found = 1'b0;
                    for (int d = 0; d < 10; d++)
                        if (lut[d] == seg_DATA) begin seen[pos] = d; found = 1'b1; end
                    if (!found) seen[pos] = 99;
                end
            end
            for (int p = 0; p < 3; p++) check("captured_digit", seen[p], digit_of(vals[v], p));
        end

        // Value switching mid-scan: new digit visible on the very next edge.
        vseq = '{100, 200, 50};
        for (int s = 0; s < 3; s++) begin
            @(negedge clk) value = 8'(vseq[s]);
            sample();
            pos = pos_of_com(seg_COM);
            check("chg_com_valid", (pos >= 0) ? 32'd1 : 32'd0, 32'd1);
            if (pos >= 0)
                check("chg_data", {24'd0, seg_DATA}, {24'd0, lut[digit_of(vseq[s], pos)]});
            repeat (498) sample();
        end

        // Drop enable while hundreds is shown.
        found = 1'b0;
        for (int k = 0; k < 3 * int'(DC) + 2 && !found; k++) begin
            sample();
            if (seg_COM == 8'hFB) found = 1'b1;
        end
        check("wait_hundreds", found ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk) enable = 1'b0;
        sample();
        check("drop_com", {24'd0, seg_COM}, 32'hFF);
        check("drop_data", {24'd0, seg_DATA}, 32'h00);
        repeat (5) sample();
        @(negedge clk) enable = 1'b1;
        sample();
        check("reen_com", {24'd0, seg_COM}, 32'hFE);

        // Reset mid-scan with enable held high.
        repeat (DC + 37) sample();
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("midrst_com", {24'd0, seg_COM}, 32'hFF);
            check("midrst_data", {24'd0, seg_DATA}, 32'h00);
        end
        @(negedge clk) rst = 1'b0;
        cnt = '{0, 0, 0};
        for (int k = 0; k < int'(DC) + 1; k++) begin
            sample();
            if (k == 0) check("postrst_ones", {24'd0, seg_COM}, 32'hFE);
            if (seg_COM == 8'hFE) cnt[0]++;
        end
        check("postrst_dwell", cnt[0], DC);

        // Randomized segments: value, enable and reset activity vs the model.
        for (int s = 0; s < 40; s++) begin
            int len;
            len = int'($urandom_range(1, 900));
            @(negedge clk);
            value  = 8'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 14) == 0);
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                rst = 1'b0;
                if ($urandom_range(0, 99) == 0) value = 8'($urandom);
            end
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
